// File: rtl/wb_arbiter_if.sv
// Shared types and the result/writeback bus of wb_arbiter: FLU input, four buffered
// sources (load, store, FPU, bitmanip) and the two scoreboard write ports.
package wb_arbiter_pkg;
  localparam int TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
endpackage

interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                                flu_valid_i;
  logic [TRANS_ID_BITS-1:0]            flu_trans_id_i;
  logic [63:0]                         flu_result_i;
  exception_t                          flu_exception_i;

  logic [3:0]                          src_valid_i;
  logic [3:0]                          src_ready_o;
  logic [3:0][TRANS_ID_BITS-1:0]       src_trans_id_i;
  logic [3:0][63:0]                    src_result_i;
  exception_t [3:0]                    src_exception_i;

  logic [1:0]                          wb_valid_o;
  logic [1:0][TRANS_ID_BITS-1:0]       wb_trans_id_o;
  logic [1:0][63:0]                    wb_result_o;
  exception_t [1:0]                    wb_exception_o;

  modport master (
    output flu_valid_i, flu_trans_id_i, flu_result_i, flu_exception_i,
    output src_valid_i, src_trans_id_i, src_result_i, src_exception_i,
    input  src_ready_o,
    input  wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o
  );

  modport slave (
    input  flu_valid_i, flu_trans_id_i, flu_result_i, flu_exception_i,
    input  src_valid_i, src_trans_id_i, src_result_i, src_exception_i,
    output src_ready_o,
    output wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: port 0 registers the FLU result, port 1 drains four per-source FIFOs
// round-robin. Define WB_ARB_FLU_SHARE_EN to let port 0 also drain a FIFO when the FLU is idle.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               exception;
  } entry_t;

  entry_t           mem_q    [4][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [4];
  logic [PTR_W-1:0] rd_ptr_q [4];
  logic [CNT_W-1:0] cnt_q    [4];
  logic [1:0]       rr_q;

  entry_t     head [4];
  logic [3:0] ready;
  logic [3:0] push;
  logic [3:0] pop;

  logic       win_found;
  logic [1:0] win_idx;
  logic       share;
  logic [1:0] sec_idx;

  entry_t     port0_p1;
  entry_t     port1_p1;
  logic [1:0] vld_p1;

  // Occupancy, head entries and handshakes; ready depends on registered count only
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i]  = mem_q[i][rd_ptr_q[i]];
      ready[i] = (cnt_q[i] != FULL);
      push[i]  = !flush_i && bus.src_valid_i[i] && ready[i];
    end
  end

  // Round-robin winner: first non-empty FIFO starting at rr_q
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && (cnt_q[rr_q + 2'(k)] != '0)) begin
        win_found = 1'b1;
        win_idx   = rr_q + 2'(k);
      end
    end
  end

`ifdef WB_ARB_FLU_SHARE_EN
  logic sec_found;

  // Second winner continues the scan after the port-1 winner, for use on an idle FLU port
  always_comb begin
    sec_found = 1'b0;
    sec_idx   = win_idx;
    for (int k = 1; k < 4; k++) begin
      if (win_found && !sec_found && (cnt_q[win_idx + 2'(k)] != '0)) begin
        sec_found = 1'b1;
        sec_idx   = win_idx + 2'(k);
      end
    end
  end

  assign share = sec_found && !bus.flu_valid_i && !flush_i;
`else
  assign share   = 1'b0;
  assign sec_idx = win_idx;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pop[i] = !flush_i && ((win_found && (win_idx == 2'(i))) ||
                            (share && (sec_idx == 2'(i))));
    end
  end

  // FIFO control state and arbitration pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (share)          rr_q <= sec_idx + 2'd1;
      else if (win_found) rr_q <= win_idx + 2'd1;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides validity
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= '{trans_id:  bus.src_trans_id_i[i],
                                   result:    bus.src_result_i[i],
                                   exception: bus.src_exception_i[i]};
      end
    end
  end

  // ---- stage p1: registered writeback ports ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= '0;
      port0_p1 <= '0;
      port1_p1 <= '0;
    end else if (flush_i) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= bus.flu_valid_i || share;
      if (bus.flu_valid_i) begin
        port0_p1 <= '{trans_id:  bus.flu_trans_id_i,
                      result:    bus.flu_result_i,
                      exception: bus.flu_exception_i};
      end else if (share) begin
        port0_p1 <= head[sec_idx];
      end
      vld_p1[1] <= win_found;
      if (win_found) port1_p1 <= head[win_idx];
    end
  end

  assign bus.src_ready_o       = ready;
  assign bus.wb_valid_o        = vld_p1;
  assign bus.wb_trans_id_o[0]  = port0_p1.trans_id;
  assign bus.wb_trans_id_o[1]  = port1_p1.trans_id;
  assign bus.wb_result_o[0]    = port0_p1.result;
  assign bus.wb_result_o[1]    = port1_p1.result;
  assign bus.wb_exception_o[0] = port0_p1.exception;
  assign bus.wb_exception_o[1] = port1_p1.exception;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning entries per buffered source (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  clock.
REQ-003 SHALL have port rst_ni  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port flush_i  input  1  discard all buffered and in-flight results.
REQ-005 SHALL have ports flu_valid_i / flu_trans_id_i / flu_result_i / flu_exception_i  input  1 / TRANS_ID_BITS / 64 / exception_t  fixed-latency-unit result, no backpressure.
REQ-006 SHALL have port src_valid_i  input  [3:0]  buffered-source result valid; index 0 load, 1 store, 2 FPU, 3 bitmanip.
REQ-007 SHALL have port src_ready_o  output  [3:0]  source FIFO can accept.
REQ-008 SHALL have ports src_trans_id_i / src_result_i / src_exception_i  input  [3:0][TRANS_ID_BITS-1:0] / [3:0][63:0] / [3:0] exception_t  buffered-source payload.
REQ-009 SHALL have ports wb_valid_o / wb_trans_id_o / wb_result_o / wb_exception_o  output  [1:0] / [1:0][TRANS_ID_BITS-1:0] / [1:0][63:0] / [1:0] exception_t  scoreboard write ports; scoreboard always accepts.

Function
REQ-010 Port 0 SHALL register the FLU result: wb_valid_o[0] in cycle N+1 equals flu_valid_i in cycle N; payload captured only when flu_valid_i=1, held otherwise.
REQ-011 Each source i SHALL own a FIFO of FIFO_DEPTH entries {trans_id, result, exception}; push when src_valid_i[i] & src_ready_o[i].
REQ-012 src_ready_o[i] SHALL be 1 iff FIFO i not full, derived from registered state only (no combinational path from any input).
REQ-013 Valid while not ready SHALL be ignored (no push, no state change).
REQ-014 Arbiter SHALL keep a 2-bit pointer rr_q; winner = first non-empty FIFO scanning rr_q, rr_q+1, ... mod 4.
REQ-015 Winner SHALL be popped and registered into port 1 in the same edge; rr_q <= winner+1 mod 4.
REQ-016 No non-empty FIFO: wb_valid_o[1] <= 0, rr_q unchanged, payload held.
REQ-017 Entry pushed at edge N SHALL be eligible from cycle N+1 (no bypass); minimum input-to-wb_valid_o latency 2 cycles.
REQ-018 Push and pop of the same FIFO in one cycle SHALL both take effect; occupancy unchanged.
REQ-019 FIFO pointers SHALL wrap mod FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-020 Payloads, including exception valid/cause/tval, SHALL pass unmodified; order within one source preserved.
REQ-021 flush_i=1 SHALL, at next edge: empty all FIFOs, clear wb_valid_o[1:0], rr_q <= 0; inputs presented in the flush cycle (FLU included) discarded.

Reset
REQ-022 While rst_ni=0: wb_valid_o=0, wb_trans_id_o=0, wb_result_o=0, wb_exception_o=0, all FIFOs empty, src_ready_o=4'b1111, rr_q=0.
REQ-023 Reset asserted mid-operation SHALL drop all buffered entries immediately, no partial writeback after release.

Configuration
REQ-024 Macro WB_ARB_FLU_SHARE_EN defined: in cycles with flu_valid_i=0 (and flush_i=0), port 0 SHALL also pop the next non-empty FIFO after the port-1 winner in round-robin order; rr_q <= that second winner+1 mod 4.
REQ-025 Macro not defined: port 0 SHALL carry only FLU results.

Verification
REQ-026 Reset release, no stimulus -> src_ready_o=4'b1111, wb_valid_o=2'b00 indefinitely.
REQ-027 flu_valid_i=1, trans_id=3, result=64'hDEAD at cycle 0 -> wb_valid_o[0]=1, trans_id 3, result 64'hDEAD at cycle 1.
REQ-028 src_valid_i=4'b1111 one cycle, ids 0..3, rr_q=0, no macro -> port 1 emits ids 0,1,2,3 in cycles 2,3,4,5; with macro and FLU idle -> port1/port0 emit {0,1} cycle 2, {2,3} cycle 3.
REQ-029 Load held valid 3 cycles, FIFO_DEPTH=2, store FIFO never empty -> src_ready_o[0]=0 after two pushes, third beat accepted only after a pop; load ids emitted in push order.
REQ-030 FIFOs 0 and 2 each hold 2 entries, flush_i=1 cycle 10 -> cycle 11 wb_valid_o=0, src_ready_o=4'b1111, nothing emitted later.
REQ-031 Load exception valid=1, cause=5, tval=64'h1000 -> wb_exception_o[1] matches exactly two cycles later.
